// File: rtl/ram_arb_pkg.sv
// Shared definitions for the CPU/video SRAM arbiter: state encoding and
// fixed bus widths.
package ram_arb_pkg;

  localparam int ADR_W  = 20;  // byte address into the SRAM
  localparam int VADR_W = 18;  // video word address
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GNT_CPU = 2'b01,
    GNT_VID = 2'b10
  } state_t;

endpackage

// File: rtl/ram_arb.sv
// Two-requester SRAM arbiter. The CPU and video fetch share a single SRAM
// controller. Grants alternate when both requesters are active, using a
// last-grant flag. The ram_* bus is a mux that the registered grant state
// selects, so a new grant reaches the controller in the same cycle that the
// state changes.
module ram_arb
  import ram_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_en,
  input  logic              cpu_ben,
  input  logic              cpu_wr,
  input  logic [ADR_W-1:0]  cpu_adr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_wait,
  input  logic              vid_req,
  input  logic [VADR_W-1:0] vid_adr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_data,
  output logic [ADR_W-1:0]  ram_adr,
  output logic              ram_en,
  output logic              ram_ben,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic              ram_wait
);

  state_t state;
  logic   last_vid;   // 1 when the most recent completed access was video
  logic   cpu_done;
  logic   vid_done;

  // A CPU cycle only completes while the CPU still drives ram_en. A video
  // cycle always has ram_en high, so it completes as soon as the controller
  // releases wait, even if vid_req falls in that same cycle.
  assign cpu_done = (state == GNT_CPU) && cpu_en && !ram_wait;
  assign vid_done = (state == GNT_VID) && !ram_wait;

  // Grant FSM. Reset is asynchronous, so a reset in the middle of an access
  // drops the bus straight away and loses the access. On completion the
  // finishing side hands over to the other requester with no idle cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_vid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cpu_en && vid_req) state <= last_vid ? GNT_CPU : GNT_VID;
          else if (vid_req)      state <= GNT_VID;
          else if (cpu_en)       state <= GNT_CPU;
        end
        GNT_CPU: begin
          if (!cpu_en) begin
            state <= IDLE;                    // abort, last_vid untouched
          end else if (cpu_done) begin
            last_vid <= 1'b0;
            state    <= vid_req ? GNT_VID : IDLE;
          end
        end
        GNT_VID: begin
          if (vid_done) begin
            last_vid <= 1'b1;
            state    <= cpu_en ? GNT_CPU : IDLE;
          end else if (!vid_req) begin
            state <= IDLE;                    // abort, last_vid untouched
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // SRAM bus mux, selected by the registered grant.
  always_comb begin
    ram_adr = '0;
    ram_en  = 1'b0;
    ram_ben = 1'b0;
    ram_wr  = 1'b0;
    ram_din = '0;
    unique case (state)
      GNT_CPU: begin
        ram_adr = cpu_adr;
        ram_en  = cpu_en;
        ram_ben = cpu_ben;
        ram_wr  = cpu_wr;
        ram_din = cpu_din;
      end
      GNT_VID: begin
        ram_adr = {vid_adr, 2'b00};
        ram_en  = 1'b1;
      end
      default: ;
    endcase
  end

  assign cpu_wait = cpu_en & ~((state == GNT_CPU) & ~ram_wait);
  assign cpu_dout = ram_dout;
  assign vid_data = ram_dout;
  assign vid_ack  = vid_done;

endmodule

// File: tb/tb_ram_arb.sv
// Bench for ram_arb: directed vector table, hand-written corner sequences
// and randomized traffic, all compared against a grant-ownership model.
module tb_ram_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_en, cpu_ben, cpu_wr;
  logic [19:0] cpu_adr;
  logic [31:0] cpu_din, cpu_dout;
  logic        cpu_wait;
  logic        vid_req;
  logic [17:0] vid_adr;
  logic        vid_ack;
  logic [31:0] vid_data;
  logic [19:0] ram_adr;
  logic        ram_en, ram_ben, ram_wr;
  logic [31:0] ram_din, ram_dout;
  logic        ram_wait;

  int checks = 0;
  int errors = 0;

  ram_arb dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_en(cpu_en), .cpu_ben(cpu_ben), .cpu_wr(cpu_wr),
    .cpu_adr(cpu_adr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .cpu_wait(cpu_wait),
    .vid_req(vid_req), .vid_adr(vid_adr), .vid_ack(vid_ack),
    .vid_data(vid_data),
    .ram_adr(ram_adr), .ram_en(ram_en), .ram_ben(ram_ben), .ram_wr(ram_wr),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_wait(ram_wait)
  );

  always #20 clk = ~clk;

  // SRAM controller stand-in: byte access is single-cycle; a word access
  // waits in its first cycle. Read data is a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [19:0] a);
    return {12'hC3A, a} ^ 32'h5A00_0000;
  endfunction

  logic busy;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= 1'b0;
    else        busy <= ram_en & ram_wait;
  end
  assign ram_wait = ram_en & ~ram_ben & ~busy;
  assign ram_dout = mem_word(ram_adr);

  // Ownership model: 0 nobody, 1 CPU, 2 video.
  int   m_owner;
  logic m_last;
  logic m_done_cpu, m_done_vid;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called at the falling edge: compare outputs, then advance the model.
  task automatic model_check();
    logic        e_en, e_wr, e_ben, e_cw, e_va;
    logic [19:0] e_adr;
    logic [31:0] e_din;
    if (!rst_n) begin
      m_owner = 0;
      m_last  = 1'b0;
    end
    e_en = 1'b0; e_wr = 1'b0; e_ben = 1'b0; e_adr = '0; e_din = '0;
    if (m_owner == 1) begin
      e_en = cpu_en; e_wr = cpu_wr; e_ben = cpu_ben; e_adr = cpu_adr; e_din = cpu_din;
    end else if (m_owner == 2) begin
      e_en = 1'b1; e_adr = 20'(vid_adr) * 20'd4;
    end
    e_cw = cpu_en && !(m_owner == 1 && !ram_wait);
    e_va = (m_owner == 2) && !ram_wait;
    chk("m_ram_en",   32'(ram_en),   32'(e_en));
    chk("m_ram_wr",   32'(ram_wr),   32'(e_wr));
    chk("m_ram_ben",  32'(ram_ben),  32'(e_ben));
    chk("m_ram_adr",  32'(ram_adr),  32'(e_adr));
    chk("m_ram_din",  ram_din,       e_din);
    chk("m_cpu_wait", 32'(cpu_wait), 32'(e_cw));
    chk("m_vid_ack",  32'(vid_ack),  32'(e_va));
    chk("m_cpu_dout", cpu_dout,      mem_word(e_adr));
    chk("m_vid_data", vid_data,      mem_word(e_adr));
    m_done_cpu = (m_owner == 1) && cpu_en && !ram_wait;
    m_done_vid = e_va;
    if (rst_n) begin
      if (m_owner == 0) begin
        if (cpu_en && vid_req) m_owner = m_last ? 1 : 2;
        else if (vid_req)      m_owner = 2;
        else if (cpu_en)       m_owner = 1;
      end else if (m_owner == 1) begin
        if (!cpu_en) m_owner = 0;
        else if (m_done_cpu) begin m_last = 1'b0; m_owner = vid_req ? 2 : 0; end
      end else begin
        if (m_done_vid) begin m_last = 1'b1; m_owner = cpu_en ? 1 : 0; end
        else if (!vid_req) m_owner = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_en = 0; cpu_ben = 0; cpu_wr = 0; cpu_adr = '0; cpu_din = '0;
    vid_req = 0; vid_adr = '0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst_n = 1'b0;
    m_owner = 0; m_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        rst;
    logic        c_en, c_ben, c_wr;
    logic [19:0] c_adr;
    logic [31:0] c_din;
    logic        v_req;
    logic [17:0] v_adr;
    logic        e_en, e_wr, e_ben;
    logic [19:0] e_adr;
    logic [31:0] e_din;
    logic        e_cwait, e_vack;
  } vec_t;

  vec_t tbl[14];

  byte  seq[$];
  int   cpu_run, vid_run, max_run, ncomp;

  initial begin
    // Reset state, with cpu_en high to see cpu_wait follow it.
    idle_inputs();
    rst_n = 1'b0;
    cpu_en = 1'b1;
    #5;
    chk("rst_ram_en",   32'(ram_en),   32'd0);
    chk("rst_ram_wr",   32'(ram_wr),   32'd0);
    chk("rst_vid_ack",  32'(vid_ack),  32'd0);
    chk("rst_cpu_wait", 32'(cpu_wait), 32'd1);
    @(negedge clk);
    chk("rst_ram_en_clk",   32'(ram_en),   32'd0);
    chk("rst_cpu_wait_clk", 32'(cpu_wait), 32'd1);
    cpu_en = 1'b0;
    #1;
    chk("rst_cpu_wait_lo", 32'(cpu_wait), 32'd0);
    reset_dut();

    //           rst c_en ben wr adr       din           vreq vadr      | en wr ben adr       din           cw va
    tbl[0]  = '{1, 1,0,0, 20'h00104, 32'h0,        0, 18'h0,     0,0,0, 20'h0,     32'h0,        1,0};
    tbl[1]  = '{1, 1,0,0, 20'h00104, 32'h0,        0, 18'h0,     1,0,0, 20'h00104, 32'h0,        1,0};
    tbl[2]  = '{1, 1,0,0, 20'h00104, 32'h0,        0, 18'h0,     1,0,0, 20'h00104, 32'h0,        0,0};
    tbl[3]  = '{1, 0,0,0, 20'h0,     32'h0,        0, 18'h0,     0,0,0, 20'h0,     32'h0,        0,0};
    tbl[4]  = '{0, 0,0,0, 20'h0,     32'h0,        0, 18'h0,     0,0,0, 20'h0,     32'h0,        0,0};
    tbl[5]  = '{1, 1,0,1, 20'h00200, 32'hDEADBEEF, 1, 18'h12345, 0,0,0, 20'h0,     32'h0,        1,0};
    tbl[6]  = '{1, 1,0,1, 20'h00200, 32'hDEADBEEF, 1, 18'h12345, 1,0,0, 20'h48D14, 32'h0,        1,0};
    tbl[7]  = '{1, 1,0,1, 20'h00200, 32'hDEADBEEF, 1, 18'h12345, 1,0,0, 20'h48D14, 32'h0,        1,1};
    tbl[8]  = '{1, 1,0,1, 20'h00200, 32'hDEADBEEF, 0, 18'h12345, 1,1,0, 20'h00200, 32'hDEADBEEF, 1,0};
    tbl[9]  = '{1, 1,0,1, 20'h00200, 32'hDEADBEEF, 0, 18'h12345, 1,1,0, 20'h00200, 32'hDEADBEEF, 0,0};
    tbl[10] = '{1, 0,0,0, 20'h0,     32'h0,        0, 18'h0,     0,0,0, 20'h0,     32'h0,        0,0};
    tbl[11] = '{1, 1,1,1, 20'h00003, 32'h000000AB, 0, 18'h0,     0,0,0, 20'h0,     32'h0,        1,0};
    tbl[12] = '{1, 1,1,1, 20'h00003, 32'h000000AB, 0, 18'h0,     1,1,1, 20'h00003, 32'h000000AB, 0,0};
    tbl[13] = '{1, 0,0,0, 20'h0,     32'h0,        0, 18'h0,     0,0,0, 20'h0,     32'h0,        0,0};

    for (int i = 0; i < 14; i++) begin
      rst_n   = tbl[i].rst;
      cpu_en  = tbl[i].c_en;  cpu_ben = tbl[i].c_ben; cpu_wr = tbl[i].c_wr;
      cpu_adr = tbl[i].c_adr; cpu_din = tbl[i].c_din;
      vid_req = tbl[i].v_req; vid_adr = tbl[i].v_adr;
      @(negedge clk);
      chk($sformatf("t%0d_ram_en", i),   32'(ram_en),   32'(tbl[i].e_en));
      chk($sformatf("t%0d_ram_wr", i),   32'(ram_wr),   32'(tbl[i].e_wr));
      chk($sformatf("t%0d_ram_ben", i),  32'(ram_ben),  32'(tbl[i].e_ben));
      chk($sformatf("t%0d_ram_adr", i),  32'(ram_adr),  32'(tbl[i].e_adr));
      chk($sformatf("t%0d_ram_din", i),  ram_din,       tbl[i].e_din);
      chk($sformatf("t%0d_cpu_wait", i), 32'(cpu_wait), 32'(tbl[i].e_cwait));
      chk($sformatf("t%0d_vid_ack", i),  32'(vid_ack),  32'(tbl[i].e_vack));
      model_check();
      tick();
    end

    // Reset during the first cycle of a video grant, then re-grant.
    reset_dut();
    vid_req = 1'b1; vid_adr = 18'h00ABC;
    @(negedge clk); model_check(); tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rv_ram_en", 32'(ram_en), 32'd0);
    chk("rv_vid_ack", 32'(vid_ack), 32'd0);
    model_check(); tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rv_idle_en", 32'(ram_en), 32'd0);
    model_check(); tick();
    @(negedge clk);
    chk("rv_regrant_en", 32'(ram_en), 32'd1);
    chk("rv_regrant_adr", 32'(ram_adr), 32'h02AF0);
    model_check(); tick();

    // CPU drops a word access mid-way; the pending video request is served.
    reset_dut();
    cpu_en = 1'b1; cpu_adr = 20'h00500;
    @(negedge clk); model_check(); tick();
    vid_req = 1'b1; vid_adr = 18'h00111;
    @(negedge clk);
    chk("ab_cpu_en", 32'(ram_en), 32'd1);
    chk("ab_cpu_wait", 32'(cpu_wait), 32'd1);
    model_check(); tick();
    cpu_en = 1'b0;
    @(negedge clk);
    chk("ab_drop_en", 32'(ram_en), 32'd0);
    chk("ab_drop_ack", 32'(vid_ack), 32'd0);
    model_check(); tick();
    @(negedge clk);
    chk("ab_idle_en", 32'(ram_en), 32'd0);
    model_check(); tick();
    @(negedge clk);
    chk("ab_vid_en", 32'(ram_en), 32'd1);
    chk("ab_vid_adr", 32'(ram_adr), 32'h00444);
    model_check(); tick();
    @(negedge clk);
    chk("ab_vid_ack", 32'(vid_ack), 32'd1);
    model_check(); tick();
    vid_req = 1'b0;

    // Both requesters held: grants alternate and waits stay bounded.
    reset_dut();
    cpu_en = 1'b1; cpu_adr = 20'h00800; vid_req = 1'b1; vid_adr = 18'h00200;
    cpu_run = 0; vid_run = 0; max_run = 0; ncomp = 0;
    for (int c = 0; c < 40 && ncomp < 8; c++) begin
      @(negedge clk);
      model_check();
      if (vid_ack) begin
        seq.push_back("V");
        if (ncomp >= 2 && vid_run > max_run) max_run = vid_run;
        vid_run = 0; ncomp++;
      end else vid_run++;
      if (!cpu_wait) begin
        seq.push_back("C");
        if (ncomp >= 2 && cpu_run > max_run) max_run = cpu_run;
        cpu_run = 0; ncomp++;
      end else cpu_run++;
      tick();
    end
    chk("alt_count", 32'(ncomp >= 8), 32'd1);
    if (seq.size() > 0) chk("alt_first", 32'(seq[0]), 32'("V"));
    for (int k = 1; k < seq.size(); k++)
      chk($sformatf("alt_%0d", k), 32'(seq[k] != seq[k-1]), 32'd1);
    chk("alt_max_wait", 32'(max_run <= 3), 32'd1);
    idle_inputs();

    // Randomized traffic with aborts and occasional resets.
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      model_check();
      tick();
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      if (!cpu_en || m_done_cpu) begin
        if ($urandom_range(0, 2) != 0) begin
          cpu_en  = 1'b1;
          cpu_ben = 1'($urandom_range(0, 1));
          cpu_wr  = 1'($urandom_range(0, 1));
          cpu_adr = 20'($urandom);
          cpu_din = $urandom;
        end else cpu_en = 1'b0;
      end else if ($urandom_range(0, 15) == 0) cpu_en = 1'b0;
      if (!vid_req || m_done_vid) begin
        if ($urandom_range(0, 2) != 0) begin
          vid_req = 1'b1;
          vid_adr = 18'($urandom);
        end else vid_req = 1'b0;
      end else if ($urandom_range(0, 15) == 0) vid_req = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arb.md
RAM_ARB -- requirements
Module: ram_arb

Interface
REQ-001 The block SHALL have no parameters; address width is fixed at 20 (byte address) and data width at 32.
REQ-002 clk  input  1  system clock (25 MHz); all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 cpu_en / cpu_ben / cpu_wr  input  1 each  CPU access request, byte enable, write.
REQ-005 cpu_adr  input  20  CPU byte address; cpu_din  input  32  CPU write data.
REQ-006 cpu_dout  output  32  read data to CPU; cpu_wait  output  1  CPU stall.
REQ-007 vid_req  input  1  video word-read request (level); vid_adr  input  18  video word address.
REQ-008 vid_ack  output  1  one-cycle completion strobe; vid_data  output  32  read word, valid when vid_ack=1.
REQ-009 ram_adr  output  20; ram_en, ram_ben, ram_wr  output  1 each; ram_din  output  32  to SRAM controller.
REQ-010 ram_dout  input  32; ram_wait  input  1  from SRAM controller (word access: wait=1 first cycle, 0 second).

Function
REQ-011 FSM states SHALL be IDLE, GNT_CPU, GNT_VID; state register plus one last-grant flag (last_vid).
REQ-012 IDLE: ram_en=0, ram_wr=0, ram_ben=0, ram_adr=0, ram_din=0.
REQ-013 GNT_CPU: ram_* SHALL equal cpu_adr/cpu_en/cpu_ben/cpu_wr/cpu_din combinationally.
REQ-014 GNT_VID: ram_adr={vid_adr,2'b00}, ram_en=1, ram_ben=0, ram_wr=0, ram_din=0.
REQ-015 A cycle "completes" when state is GNT_x, ram_en=1 and ram_wait=0.
REQ-016 From IDLE: if only one requester active, grant it next cycle; if both, grant VID when last_vid=0, else CPU.
REQ-017 On completion: completing requester is ineligible for the next grant; next state = other requester's grant if it is requesting, else IDLE; last_vid updated to the completing requester.
REQ-018 Request-to-first-RAM-cycle latency SHALL be exactly 1 cycle from IDLE; back-to-back grants SHALL have zero idle cycles.
REQ-019 cpu_wait = cpu_en & ~(state==GNT_CPU & ~ram_wait).
REQ-020 cpu_dout = ram_dout unconditionally; vid_data = ram_dout; vid_ack = completion in GNT_VID.
REQ-021 CPU byte access (cpu_ben=1) SHALL complete in its first granted cycle; word access in its second.
REQ-022 If cpu_en drops while in GNT_CPU, or vid_req drops while in GNT_VID, before completion, state SHALL go to IDLE next cycle (abort), last_vid unchanged.
REQ-023 Requesters hold request and address stable until completion; arbiter SHALL NOT preempt a granted access.
REQ-024 Worst-case wait for either requester SHALL be bounded by one full access of the other (≤ 3 cycles).

Reset
REQ-025 rst_n=0 SHALL force state=IDLE and last_vid=0 immediately, independent of clk.
REQ-026 During and after reset until a grant: ram_en=0, ram_wr=0, vid_ack=0; cpu_wait=cpu_en.
REQ-027 Reset asserted mid-access SHALL drop ram_en and ram_wr within the same cycle; the access is lost.
REQ-028 Reset release SHALL be synchronized by the parent; first grant no earlier than the first clk edge with rst_n=1.

Structure
REQ-029 State encoding (IDLE=2'b00, GNT_CPU=2'b01, GNT_VID=2'b10) SHALL live in shared package ram_arb_pkg.
REQ-030 The block SHALL be a single module with no sub-module; the SRAM controller is instantiated by the parent, not here.
REQ-031 All outputs except state-derived strobes SHALL be combinational muxes selected by the registered state.

Verification
REQ-032 CPU word read 0x00104 alone, ram_wait 1,0 -> cpu_wait 1,1,0 over three cycles; cpu_dout=ram_dout in third; vid_ack stays 0.
REQ-033 vid_req and cpu_en (write word 0x00200, din 0xDEADBEEF) rise same cycle after reset -> GNT_VID first (last_vid=0), vid_ack after 2 cycles, then GNT_CPU with no idle cycle, ram_din=0xDEADBEEF.
REQ-034 Both held continuously for 8 accesses -> grants strictly alternate VID,CPU,VID,...; no requester waits >3 cycles.
REQ-035 CPU byte write 0x00003 -> ram_ben=1, ram_wr=1 exactly one cycle, cpu_wait 1 then 0.
REQ-036 rst_n low during first cycle of GNT_VID -> ram_en=0 same cycle, no vid_ack, state IDLE; after release vid_req re-granted in 1 cycle.
REQ-037 cpu_en dropped mid word access -> IDLE next cycle, pending vid_req granted from IDLE by REQ-016.
